addsub_serial_responder: RTL and testbench
==========================================

// Module: addsub_serial_responder
// PURPOSE
//  Responder end of the add/subtract operation interface. Accepts one op request
//  (op select, two operands) over a valid/ready handshake. Computes the result
//  bit-serially, LSB first, one bit per clk. Returns the result on a valid/ready
//  response channel.
//  Sits behind any initiator that dispatches add/sub commands. Trades latency for
//  a single 1-bit adder slice.
// PARAMETERS
//  WIDTH  4  operand/result width in bits (>=2); also CALC cycle count
// PORTS
//  clk         in   1      rising-edge clock; single clock domain
//  rst         in   1      synchronous, active-high reset
//  req_valid   in   1      request present
//  req_ready   out  1      responder can accept a request (high only in IDLE)
//  req_op      in   1      1 = add (a+b), 0 = subtract (a-b)
//  req_a       in   WIDTH  operand a
//  req_b       in   WIDTH  operand b
//  rsp_valid   out  1      result available
//  rsp_ready   in   1      initiator accepts result
//  rsp_result  out  WIDTH  result, modulo 2^WIDTH
//  rsp_flag    out  1      add: carry out; sub: borrow (1 when a<b unsigned)
// BEHAVIOUR
//  - Reset: state=IDLE, req_ready=1 on the cycle after rst deasserts (0 while rst),
//    rsp_valid=0, rsp_result=0, rsp_flag=0, bit counter=0.
//  - FSM IDLE -> CALC -> RESP -> IDLE. Moore outputs; req_ready=(state==IDLE).
//  - IDLE:
//    - on req_valid&&req_ready, latch a, b, op; go to CALC.
//    - carry register initialised to ~op (sub computes a + ~b + 1).
//    - no request: stay.
//  - CALC:
//    - each clk computes bit i = a[i]^b'[i]^c, where b'=op?b:~b; carry updated.
//    - result shifts in from MSB side; counter increments.
//    - after WIDTH CALC cycles go to RESP.
//    - req_* ignored; operand pins may change freely.
//  - RESP:
//    - rsp_valid=1; rsp_result/rsp_flag held stable until rsp_valid&&rsp_ready.
//    - on handshake: go to IDLE, clear rsp_valid. rsp_result keeps its last value.
//    - rsp_ready low: stay (backpressure), req_ready stays 0.
//  - rsp_flag: add = final carry; sub = ~final carry.
//  - Latency: acceptance edge E0. rsp_valid is high in the cycle after edge E(WIDTH),
//    i.e. exactly WIDTH clks after acceptance.
//  - Throughput: one op per WIDTH+2 clks minimum (IDLE cycle mandatory between ops).
//  - rsp_ready high while not in RESP: no effect.
//  - rst mid-CALC or mid-RESP: in-flight op dropped, all outputs to reset values
//    next edge, no response emitted.
//  - rst has priority over every handshake on the same edge.
// STRUCTURE
//  - Shared package/include addsub_pkg:
//    - OP_ADD=1'b1, OP_SUB=1'b0.
//    - state encoding ST_IDLE=2'd0, ST_CALC=2'd1, ST_RESP=2'd2.
//  - Sub-module addsub_bit_slice: combinational 1-bit full adder (a, b, cin -> s, cout).
//    Instantiated once.
//  - Top holds FSM, operand shift registers, carry flop, $clog2(WIDTH+1)-bit counter.
// TESTING (WIDTH=4)
//  1 add 4+3, rsp_ready=1 -> rsp_result=7, flag=0; rsp_valid exactly 4 clks after
//    accept; 1 cycle.
//  2 add 9+9 -> result=2, flag=1; sub 7-7 -> result=0, flag=0.
//  3 sub 3-5 -> result=14, flag=1; sub 15-0 -> result=15, flag=0.
//  4 backpressure: rsp_ready=0 for 5 clks -> rsp_valid, result, flag stable;
//    req_ready=0; new req_valid not accepted.
//  5 operand change during CALC (a,b toggled each clk) -> result matches latched
//    operands only.
//  6 rst asserted 2 clks into CALC -> next cycle: rsp_valid=0, result=0;
//    after rst drops, req_ready=1; next op 1+1 -> 2.

Source files
------------

// File: rtl/addsub_pkg.sv
// addsub_pkg: shared opcode and FSM state definitions for the add/subtract
// operation interface (initiator and responder sides).
package addsub_pkg;

  // Request opcode values carried on req_op
  localparam logic OP_ADD = 1'b1;
  localparam logic OP_SUB = 1'b0;

  // Responder FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage : addsub_pkg

// File: rtl/addsub_bit_slice.sv
// addsub_bit_slice: combinational 1-bit full adder.
// Ports:
//   i_a, i_b  in   operand bits
//   i_cin     in   carry in
//   o_s       out  sum bit
//   o_cout    out  carry out
module addsub_bit_slice (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_s,
  output logic o_cout
);

  assign o_s    = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);

endmodule : addsub_bit_slice

// File: rtl/addsub_serial_responder.sv
// addsub_serial_responder: accepts one add/sub request over valid/ready,
// computes the result one bit per clock (LSB first) through a single full-adder
// slice, and returns result + carry/borrow flag over a valid/ready response.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req_valid/req_ready   request handshake (ready only in IDLE)
//   req_op                1 = add, 0 = subtract
//   req_a, req_b          operands, WIDTH bits
//   rsp_valid/rsp_ready   response handshake
//   rsp_result            result modulo 2^WIDTH
//   rsp_flag              add: carry out; sub: borrow (a < b unsigned)
module addsub_serial_responder
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_flag
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_t             r_state;
  logic               r_req_ready;
  logic               r_rsp_valid;
  logic [WIDTH-1:0]   r_rsp_result;
  logic               r_rsp_flag;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_op;
  logic               r_carry;
  logic [WIDTH-1:0]   r_res;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_b_eff;
  logic               w_sum;
  logic               w_cout;
  logic [WIDTH-1:0]   w_res_next;

  // Subtract is a + ~b + 1: invert b here, the +1 comes from the carry seed
  assign w_b_eff    = (r_op == OP_ADD) ? r_b[0] : ~r_b[0];
  assign w_res_next = {w_sum, r_res[WIDTH-1:1]};

  addsub_bit_slice u_slice (
    .i_a    (r_a[0]),
    .i_b    (w_b_eff),
    .i_cin  (r_carry),
    .o_s    (w_sum),
    .o_cout (w_cout)
  );

  // FSM, operand shifters, carry and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_req_ready  <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_flag   <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_op         <= OP_SUB;
      r_carry      <= 1'b0;
      r_res        <= '0;
      r_cnt        <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_req_ready <= 1'b1;
          if (req_valid && r_req_ready) begin
            r_a         <= req_a;
            r_b         <= req_b;
            r_op        <= req_op;
            r_carry     <= ~req_op;
            r_cnt       <= '0;
            r_req_ready <= 1'b0;
            r_state     <= ST_CALC;
          end
        end
        ST_CALC: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_carry <= w_cout;
          r_res   <= w_res_next;
          r_cnt   <= r_cnt + CNT_W'(1);
          // Last bit: publish the completed result in the same edge
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            r_state      <= ST_RESP;
            r_rsp_valid  <= 1'b1;
            r_rsp_result <= w_res_next;
            r_rsp_flag   <= (r_op == OP_ADD) ? w_cout : ~w_cout;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_flag   = r_rsp_flag;

endmodule : addsub_serial_responder

// File: tb/tb_addsub_serial_responder.sv
// tb_addsub_serial_responder: table-driven vectors, directed multi-cycle
// sequences and random ops against an arithmetic reference model.
module tb_addsub_serial_responder;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic         req_op;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_result;
  logic         rsp_flag;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  addsub_serial_responder #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_flag   (rsp_flag)
  );

  typedef struct {
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_res;
    logic         exp_flag;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic, result mod 2^W, flag = carry/borrow
  function automatic logic [W:0] model(input logic op, input logic [W-1:0] a,
                                       input logic [W-1:0] b);
    int s;
    logic fl;
    s  = op ? (int'(a) + int'(b)) : (int'(a) - int'(b));
    fl = op ? (s >= (1 << W)) : (s < 0);
    return {fl, W'(s & ((1 << W) - 1))};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, wait for rsp_valid; optionally scramble operand pins
  task automatic do_op(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit scramble, output int lat);
    int k;
    k = 0;
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    while (!req_ready && k < 20) begin
      step();
      k++;
    end
    if (!req_ready) chk("req_ready_timeout", 0, 1);
    step();
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      if (scramble) begin
        req_a  = ~req_a;
        req_b  = W'($urandom);
        req_op = ~req_op;
      end
      step();
      lat++;
    end
  endtask

  int          lat;
  logic [W:0]  m;
  logic [W-1:0] held_res;
  logic         held_flag;

  initial begin
    vecs[0] = '{1'b1, 4'd4,  4'd3, 4'd7,  1'b0};
    vecs[1] = '{1'b1, 4'd9,  4'd9, 4'd2,  1'b1};
    vecs[2] = '{1'b0, 4'd7,  4'd7, 4'd0,  1'b0};
    vecs[3] = '{1'b0, 4'd3,  4'd5, 4'd14, 1'b1};
    vecs[4] = '{1'b0, 4'd15, 4'd0, 4'd15, 1'b0};
    vecs[5] = '{1'b1, 4'd15, 4'd1, 4'd0,  1'b1};
    vecs[6] = '{1'b0, 4'd0,  4'd1, 4'd15, 1'b1};

    rst = 1'b1; req_valid = 1'b0; req_op = 1'b0; req_a = '0; req_b = '0;
    rsp_ready = 1'b1;
    step(); step(); step();
    chk("rst_req_ready", int'(req_ready), 0);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_result",    int'(rsp_result), 0);
    chk("rst_flag",      int'(rsp_flag), 0);
    rst = 1'b0;
    step();
    chk("post_rst_req_ready", int'(req_ready), 1);

    // Table vectors with rsp_ready held high
    for (int i = 0; i < 7; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, lat);
      chk($sformatf("vec%0d_latency", i), lat, W);
      chk($sformatf("vec%0d_valid", i), int'(rsp_valid), 1);
      chk($sformatf("vec%0d_result", i), int'(rsp_result), int'(vecs[i].exp_res));
      chk($sformatf("vec%0d_flag", i), int'(rsp_flag), int'(vecs[i].exp_flag));
      chk($sformatf("vec%0d_req_ready_busy", i), int'(req_ready), 0);
      step();
      chk($sformatf("vec%0d_valid_one_cycle", i), int'(rsp_valid), 0);
      chk($sformatf("vec%0d_req_ready_back", i), int'(req_ready), 1);
      chk($sformatf("vec%0d_result_kept", i), int'(rsp_result), int'(vecs[i].exp_res));
    end

    // Backpressure: response held, new request refused
    rsp_ready = 1'b0;
    do_op(1'b0, 4'd3, 4'd5, 1'b0, lat);
    chk("bp_latency", lat, W);
    req_valid = 1'b1; req_op = 1'b1; req_a = 4'd1; req_b = 4'd2;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("bp_valid",     int'(rsp_valid), 1);
      chk("bp_result",    int'(rsp_result), 14);
      chk("bp_flag",      int'(rsp_flag), 1);
      chk("bp_req_ready", int'(req_ready), 0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    chk("bp_release_valid", int'(rsp_valid), 0);
    chk("bp_release_ready", int'(req_ready), 1);
    step(); step(); step(); step(); step();
    chk("bp_no_ghost_op", int'(rsp_valid), 0);
    chk("bp_no_ghost_result", int'(rsp_result), 14);

    // Operand pins toggled during CALC
    do_op(1'b1, 4'd5, 4'd6, 1'b1, lat);
    chk("scr_latency", lat, W);
    chk("scr_result",  int'(rsp_result), 11);
    chk("scr_flag",    int'(rsp_flag), 0);
    step();

    // Reset two cycles into CALC
    req_valid = 1'b1; req_op = 1'b1; req_a = 4'd6; req_b = 4'd7;
    while (!req_ready) step();
    step();
    req_valid = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    chk("midrst_valid",     int'(rsp_valid), 0);
    chk("midrst_result",    int'(rsp_result), 0);
    chk("midrst_req_ready", int'(req_ready), 0);
    rst = 1'b0;
    step();
    chk("midrst_ready_after", int'(req_ready), 1);
    for (int c = 0; c < 6; c++) begin
      step();
      chk("midrst_no_rsp", int'(rsp_valid), 0);
    end
    do_op(1'b1, 4'd1, 4'd1, 1'b0, lat);
    chk("midrst_next_lat",    lat, W);
    chk("midrst_next_result", int'(rsp_result), 2);
    chk("midrst_next_flag",   int'(rsp_flag), 0);
    step();

    // Random ops with random backpressure against the model
    for (int n = 0; n < 40; n++) begin
      logic         op;
      logic [W-1:0] a, b;
      int           hold;
      op   = 1'($urandom);
      a    = W'($urandom);
      b    = W'($urandom);
      hold = int'($urandom_range(0, 3));
      m    = model(op, a, b);
      rsp_ready = (hold == 0);
      do_op(op, a, b, n[0], lat);
      chk("rnd_latency", lat, W);
      chk($sformatf("rnd%0d_result", n), int'(rsp_result), int'(m[W-1:0]));
      chk($sformatf("rnd%0d_flag", n), int'(rsp_flag), int'(m[W]));
      held_res  = rsp_result;
      held_flag = rsp_flag;
      for (int c = 0; c < hold; c++) begin
        step();
        chk("rnd_hold_valid", int'(rsp_valid), 1);
        chk("rnd_hold_stable", int'({rsp_flag, rsp_result}), int'({held_flag, held_res}));
      end
      rsp_ready = 1'b1;
      if (hold != 0) step();
      step();
      chk("rnd_done_valid", int'(rsp_valid), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_addsub_serial_responder
